// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a non-fallthrough FIFO (dout valid the cycle after rd_en) and presents
// its words as a valid/ready stream. A 2-entry buffer (head, tail) absorbs the
// one-cycle read latency so a consumer holding out_ready high gets one word per
// cycle. The read strobe looks ahead at the word already in flight and at this
// cycle's pop, so the buffer can never be asked to hold a third word.
module fifo_stream_reader #(
  parameter int WIDTH     = 72,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] words_out
);

  // Buffer occupancy; the encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                 occ_r;
  occ_e                 occ_next_s;
  logic                 inflight_r;
  logic [WIDTH-1:0]     head_r;
  logic [WIDTH-1:0]     tail_r;
  logic [WIDTH-1:0]     head_next_s;
  logic [WIDTH-1:0]     tail_next_s;
  logic [CNT_WIDTH-1:0] words_r;
  logic                 pop_s;
  logic [2:0]           level_s;
  logic                 rd_en_s;

  // Head register drives the stream directly; valid is a decode of registered state.
  assign out_valid  = (occ_r != OCC_EMPTY);
  assign out_data   = head_r;
  assign words_out  = words_r;
  assign fifo_rd_en = rd_en_s;

  // Read strobe: request a word only if the buffer will still have room once it lands.
  always_comb begin
    pop_s   = out_valid & out_ready;
    level_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (reset || fifo_empty) begin
      rd_en_s = 1'b0;
    end else begin
      rd_en_s = (level_s < 3'd2);
    end
  end

  // Occupancy next-state and buffer steering for capture and pop.
  always_comb begin
    occ_next_s  = occ_r;
    head_next_s = head_r;
    tail_next_s = tail_r;
    case (occ_r)
      OCC_EMPTY: begin
        if (inflight_r) begin
          head_next_s = fifo_dout;
          occ_next_s  = OCC_ONE;
        end else begin
          occ_next_s  = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (pop_s && inflight_r) begin
          // Head leaves and the arriving word takes its place.
          head_next_s = fifo_dout;
          occ_next_s  = OCC_ONE;
        end else if (pop_s) begin
          occ_next_s  = OCC_EMPTY;
        end else if (inflight_r) begin
          tail_next_s = fifo_dout;
          occ_next_s  = OCC_TWO;
        end else begin
          occ_next_s  = OCC_ONE;
        end
      end
      OCC_TWO: begin
        // No word can be in flight here: the strobe was held off a cycle earlier.
        if (pop_s) begin
          head_next_s = tail_r;
          occ_next_s  = OCC_ONE;
        end else begin
          occ_next_s  = OCC_TWO;
        end
      end
      default: begin
        occ_next_s = OCC_EMPTY;
      end
    endcase
  end

  // State registers; reset drops the buffer and any word still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r      <= OCC_EMPTY;
      inflight_r <= 1'b0;
      head_r     <= '0;
      tail_r     <= '0;
      words_r    <= '0;
    end else begin
      occ_r      <= occ_next_s;
      inflight_r <= rd_en_s;
      head_r     <= head_next_s;
      tail_r     <= tail_next_s;
      words_r    <= words_r + {{(CNT_WIDTH-1){1'b0}}, pop_s};
    end
  end

endmodule
